regfile_writer: RTL and testbench
=================================

# regfile_writer

Write side of the multicycle datapath's register file. Holds the 32×32 architectural register array, accepts write-back requests from the control FSM via a valid/ready handshake into a small pending-write queue, and retires one queued write per commit cycle. Provides the two combinational read ports (RFRD1/RFRD2) that feed the A/B operand latches, with bypass from pending writes so operand reads always observe program order.

## Interface
- WIDTH, 32, data width of each register
- NREGS, 32, number of architectural registers (address width = clog2(NREGS) = 5)
- DEPTH, 2, pending-write queue entries (power of two, ≥2)
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- WB_VALID  input  1  write-back request present
- WB_READY  output  1  queue can accept; high when count < DEPTH
- WB_DST  input  5  destination register
- WB_SEL  input  2  data source: 0=ALUOUT, 1=MDR, 2=PCPLUS4, 3=reserved (treated as 0)
- ALUOUT, MDR, PCPLUS4  input  WIDTH each  candidate write-back data
- WB_COMMIT  input  1  retire queue head into array this cycle
- RA1, RA2  input  5  read addresses
- RFRD1, RFRD2  output  WIDTH  read data (combinational)
- PENDING  output  clog2(DEPTH)+1  current queue occupancy

## Operation
- Enqueue on WB_VALID && WB_READY: entry {WB_DST, muxed data} written at tail; data selected by WB_SEL in the same cycle.
- WB_DST==0: handshake completes (WB_READY honored) but nothing enqueued; count unchanged.
- Commit on WB_COMMIT && count>0: head entry written into array, head pointer advances. WB_COMMIT with count==0 ignored.
- Simultaneous enqueue and commit: both occur; count unchanged; legal when full only if WB_READY was high (it is not when full, so a full queue never accepts in the commit cycle).
- Read: RA==0 → 0. Otherwise newest queued entry whose dst==RA (tail-most match) supplies data; else array contents. Read in the same cycle as enqueue does not see the new entry (visible next cycle).
- Pointers wrap modulo DEPTH.
- Register 0 never written; array[0] reads as 0 regardless.

## Timing
- Reset (RST high at edge): all array entries 0, head=tail=0, count=0; thus PENDING=0, WB_READY=1, RFRD1/RFRD2=0 for every address. Reset mid-operation discards queued writes.
- Enqueue latency: write visible on RFRDx (via bypass) the cycle after acceptance.
- Commit latency: array updated at commit edge; read value unchanged across commit (bypass → array).
- WB_READY depends only on registered count, never on WB_COMMIT in the same cycle.
- PENDING registered; reflects state after previous edge.

## Structure
- Shared package: WIDTH/NREGS constants, WB_SEL encodings (WB_ALU, WB_MEM, WB_LINK), register address type.
- One sub-module natural: wb_queue (DEPTH-entry circular buffer with per-entry address compare outputs for bypass); array, source mux and read muxes stay in regfile_writer.

## Test plan
- Reset then read RA1=5, RA2=31 → RFRD1=RFRD2=0, PENDING=0, WB_READY=1.
- Enqueue dst=3, SEL=0, ALUOUT=0xDEADBEEF; next cycle RA1=3 → 0xDEADBEEF via bypass, PENDING=1; commit → PENDING=0, RFRD1 still 0xDEADBEEF.
- Enqueue dst=7 MDR=0x11, then dst=7 PCPLUS4=0x40 (no commit) → WB_READY=0, RFRD1(RA=7)=0x40; enqueue attempt with ALUOUT=0x99 ignored; two commits → array[7]=0x40.
- Full queue, WB_COMMIT=1 and WB_VALID=1 same cycle → only commit occurs, PENDING 2→1; next cycle enqueue accepted.
- Enqueue dst=0 ALUOUT=0x1234 → PENDING stays 0, RA1=0 reads 0.
- Two entries queued, RST asserted → PENDING=0, previously queued registers read 0.

Source files
------------

// File: rtl/regfile_writer_pkg.sv
// rtl/regfile_writer_pkg.sv - shared constants and types for the register file write side
package regfile_writer_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int DEPTH = 2;
  localparam int AW    = $clog2(NREGS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [WIDTH-1:0] data_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/regfile_writer_if.sv
// rtl/regfile_writer_if.sv - write-back request, commit and read port bundle
interface regfile_writer_if;
  import regfile_writer_pkg::*;

  logic      wb_valid;
  logic      wb_ready;
  reg_addr_t wb_dst;
  logic [1:0] wb_sel;
  data_t     aluout;
  data_t     mdr;
  data_t     pcplus4;
  logic      wb_commit;
  reg_addr_t ra1;
  reg_addr_t ra2;
  data_t     rfrd1;
  data_t     rfrd2;
  cnt_t      pending;

  modport master (
    output wb_valid, wb_dst, wb_sel, aluout, mdr, pcplus4, wb_commit, ra1, ra2,
    input  wb_ready, rfrd1, rfrd2, pending
  );

  modport slave (
    input  wb_valid, wb_dst, wb_sel, aluout, mdr, pcplus4, wb_commit, ra1, ra2,
    output wb_ready, rfrd1, rfrd2, pending
  );

endinterface

// File: rtl/regfile_writer_wb_queue.sv
// rtl/regfile_writer_wb_queue.sv - circular pending-write queue with age-ordered bypass compares
module regfile_writer_wb_queue
  import regfile_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  reg_addr_t             push_dst,
  input  data_t                 push_data,
  input  logic                  pop,
  input  reg_addr_t             ra1,
  input  reg_addr_t             ra2,
  output reg_addr_t             head_dst,
  output data_t                 head_data,
  output cnt_t                  count,
  output logic                  ready,
  output logic [DEPTH-1:0]      hit1,
  output logic [DEPTH-1:0]      hit2,
  output data_t [DEPTH-1:0]     ent_data
);

  localparam cnt_t FULL = cnt_t'(DEPTH);

  reg_addr_t [DEPTH-1:0] dst_q, dst_d;
  data_t     [DEPTH-1:0] data_q, data_d;
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  cnt_t                  count_q, count_d;
  logic                  push_ok, pop_ok;
  ptr_t                  age_idx;

  assign push_ok = push && (count_q < FULL);
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    dst_d   = dst_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
    if (push_ok) begin
      dst_d[tail_q]  = push_dst;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + 1'b1;
    end
    if (pop_ok) begin
      head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q   <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      dst_q   <= dst_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot i of the outputs is the i-th oldest live entry, so higher index means newer.
  always_comb begin
    hit1     = '0;
    hit2     = '0;
    ent_data = '0;
    age_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx     = head_q + ptr_t'(i);
      ent_data[i] = data_q[age_idx];
      if (cnt_t'(i) < count_q) begin
        hit1[i] = (dst_q[age_idx] == ra1);
        hit2[i] = (dst_q[age_idx] == ra2);
      end
    end
  end

  assign head_dst  = dst_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign ready     = (count_q < FULL);

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - register array, write-back source mux, queued commit and bypassed read ports
module regfile_writer
  import regfile_writer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  regfile_writer_if.slave  bus
);

  data_t [NREGS-1:0] rf_q, rf_d;
  data_t             wb_data;
  logic              push, pop, ready;
  reg_addr_t         head_dst;
  data_t             head_data;
  cnt_t              count;
  logic [DEPTH-1:0]  hit1, hit2;
  data_t [DEPTH-1:0] ent_data;

  always_comb begin
    case (wb_sel_e'(bus.wb_sel))
      WB_MEM:  wb_data = bus.mdr;
      WB_LINK: wb_data = bus.pcplus4;
      default: wb_data = bus.aluout;
    endcase
  end

  // A write to r0 still completes the handshake; it just never occupies a slot.
  assign push = bus.wb_valid && ready && (bus.wb_dst != '0);
  assign pop  = bus.wb_commit && (count != '0);

  regfile_writer_wb_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_dst  (bus.wb_dst),
    .push_data (wb_data),
    .pop       (pop),
    .ra1       (bus.ra1),
    .ra2       (bus.ra2),
    .head_dst  (head_dst),
    .head_data (head_data),
    .count     (count),
    .ready     (ready),
    .hit1      (hit1),
    .hit2      (hit2),
    .ent_data  (ent_data)
  );

  always_comb begin
    rf_d = rf_q;
    if (pop && (head_dst != '0)) begin
      rf_d[head_dst] = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  function automatic data_t read_port(input reg_addr_t ra, input logic [DEPTH-1:0] hit,
                                      input data_t [NREGS-1:0] rf, input data_t [DEPTH-1:0] ent);
    data_t v;
    v = rf[ra];
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) v = ent[i];
    end
    if (ra == '0) v = '0;
    return v;
  endfunction

  assign bus.rfrd1    = read_port(bus.ra1, hit1, rf_q, ent_data);
  assign bus.rfrd2    = read_port(bus.ra2, hit2, rf_q, ent_data);
  assign bus.wb_ready = ready;
  assign bus.pending  = count;

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - scoreboard bench for regfile_writer against a queue-based reference model
module tb_regfile_writer;

  localparam int QDEPTH = 2;

  logic clk;
  logic rst;

  regfile_writer_if bus ();

  regfile_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] model_rf [32];
  logic [4:0]  mq_dst  [$];
  logic [31:0] mq_data [$];
  string       sb_tag  [$];
  logic [31:0] sb_val  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = mq_dst.size() - 1; i >= 0; i--) begin
      if (mq_dst[i] == a) return mq_data[i];
    end
    return model_rf[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    mq_dst.delete();
    mq_data.delete();
  endtask

  task automatic step(input bit v, input logic [4:0] dst, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] mdrv, input logic [31:0] pc4,
                      input bit cm, input logic [4:0] a1, input logic [4:0] a2, input bit r);
    logic [31:0] obs [4];
    logic [31:0] wdata;
    bit acc, pp;
    @(negedge clk);
    rst           = r;
    bus.wb_valid  = v;
    bus.wb_dst    = dst;
    bus.wb_sel    = sel;
    bus.aluout    = alu;
    bus.mdr       = mdrv;
    bus.pcplus4   = pc4;
    bus.wb_commit = cm;
    bus.ra1       = a1;
    bus.ra2       = a2;
    sb_tag.push_back("rfrd1");   sb_val.push_back(model_read(a1));
    sb_tag.push_back("rfrd2");   sb_val.push_back(model_read(a2));
    sb_tag.push_back("wb_ready"); sb_val.push_back(32'(mq_dst.size() < QDEPTH));
    sb_tag.push_back("pending"); sb_val.push_back(32'(mq_dst.size()));
    #1;
    obs[0] = bus.rfrd1;
    obs[1] = bus.rfrd2;
    obs[2] = 32'(bus.wb_ready);
    obs[3] = 32'(bus.pending);
    for (int k = 0; k < 4; k++) begin
      chk(sb_tag.pop_front(), obs[k], sb_val.pop_front());
    end
    acc = v && (mq_dst.size() < QDEPTH);
    pp  = cm && (mq_dst.size() > 0);
    case (sel)
      2'd1:    wdata = mdrv;
      2'd2:    wdata = pc4;
      default: wdata = alu;
    endcase
    if (r) begin
      model_clear();
    end else begin
      if (pp) begin
        if (mq_dst[0] != 5'd0) model_rf[mq_dst[0]] = mq_data[0];
        void'(mq_dst.pop_front());
        void'(mq_data.pop_front());
      end
      if (acc && dst != 5'd0) begin
        mq_dst.push_back(dst);
        mq_data.push_back(wdata);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_dst = '0; bus.wb_sel = '0;
    bus.aluout = '0; bus.mdr = '0; bus.pcplus4 = '0;
    bus.wb_commit = 1'b0; bus.ra1 = '0; bus.ra2 = '0;
    model_clear();
    repeat (2) @(posedge clk);

    //    v  dst   sel   alu           mdr           pc4          cm  ra1    ra2    rst
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        0, 5'd5,  5'd31, 0);
    step(1, 5'd3, 2'd0, 32'hDEADBEEF, 32'h0,        32'h0,        0, 5'd3,  5'd0,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        0, 5'd3,  5'd3,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        1, 5'd3,  5'd1,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        0, 5'd3,  5'd3,  0);
    step(1, 5'd7, 2'd1, 32'h0,        32'h11,       32'h0,        0, 5'd7,  5'd3,  0);
    step(1, 5'd7, 2'd2, 32'h0,        32'h0,        32'h40,       0, 5'd7,  5'd3,  0);
    step(1, 5'd7, 2'd0, 32'h99,       32'h0,        32'h0,        0, 5'd7,  5'd0,  0);
    step(1, 5'd9, 2'd0, 32'h55,       32'h0,        32'h0,        1, 5'd7,  5'd9,  0);
    step(1, 5'd9, 2'd0, 32'h55,       32'h0,        32'h0,        0, 5'd7,  5'd9,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        1, 5'd9,  5'd7,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        1, 5'd9,  5'd7,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        1, 5'd9,  5'd7,  0);
    step(1, 5'd0, 2'd0, 32'h1234,     32'h0,        32'h0,        0, 5'd0,  5'd9,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        0, 5'd0,  5'd0,  0);
    step(1, 5'd4, 2'd3, 32'hA5A5,     32'hFFFF,     32'hEEEE,     0, 5'd4,  5'd0,  0);
    step(1, 5'd5, 2'd1, 32'h0,        32'h5151,     32'h0,        0, 5'd4,  5'd5,  0);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        0, 5'd4,  5'd5,  1);
    step(0, 5'd0, 2'd0, 32'h0,        32'h0,        32'h0,        0, 5'd4,  5'd5,  0);

    for (int n = 0; n < 300; n++) begin
      step(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, bit'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
